// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX pipeline register with WB bypass at ID, MEM/WB forwarding
//            at EX and one-bubble load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);

    localparam logic [REG_AW-1:0] c_zero_reg = '0;
    localparam logic [DATA_W-1:0] c_zero_dat = '0;

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic [REG_AW-1:0] r_dst;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;

    logic [DATA_W-1:0] w_byp1;
    logic [DATA_W-1:0] w_byp2;
    logic              w_hz;
    logic              w_issue;

    // RF writes on the edge, so a same-cycle read still sees the old value.
    assign w_byp1 = (wb_reg_write && (wb_dst == id_rs) && (id_rs != c_zero_reg))
                    ? wb_data : rf_data1;
    assign w_byp2 = (wb_reg_write && (wb_dst == id_rt) && (id_rt != c_zero_reg))
                    ? wb_data : rf_data2;

    assign w_hz = id_valid && r_valid && r_mem_read && (r_dst != c_zero_reg)
                  && ((r_dst == id_rs) || (r_dst == id_rt));

    assign stall_id = w_hz && !flush;
    assign w_issue  = id_valid && !flush && !w_hz;

    // Data fields load every cycle; a bubble only clears the control bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_dst       <= c_zero_reg;
            r_rs        <= c_zero_reg;
            r_rt        <= c_zero_reg;
            r_val1      <= c_zero_dat;
            r_val2      <= c_zero_dat;
        end else begin
            r_valid     <= w_issue;
            r_reg_write <= w_issue && id_reg_write;
            r_mem_read  <= w_issue && id_mem_read;
            r_dst       <= id_dst;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_val1      <= w_byp1;
            r_val2      <= w_byp2;
        end
    end

    // MEM is younger than WB and wins when both target the same register.
    always_comb begin
        ex_op1 = r_val1;
        if (r_rs == c_zero_reg)
            ex_op1 = c_zero_dat;
        else if (mem_reg_write && (mem_dst == r_rs))
            ex_op1 = mem_data;
        else if (wb_reg_write && (wb_dst == r_rs))
            ex_op1 = wb_data;
    end

    always_comb begin
        ex_op2 = r_val2;
        if (r_rt == c_zero_reg)
            ex_op2 = c_zero_dat;
        else if (mem_reg_write && (mem_dst == r_rt))
            ex_op2 = mem_data;
        else if (wb_reg_write && (wb_dst == r_rt))
            ex_op2 = wb_data;
    end

    assign ex_valid     = r_valid;
    assign ex_dst       = r_dst;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Brief    : Scoreboard bench for id_ex_operand_stage: directed hazard cases
//            followed by a randomized phase against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_reg_write, id_mem_read;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [31:0] rf_data1, rf_data2;
    logic        mem_reg_write, wb_reg_write, flush;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] mem_data, wb_data;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  ex_dst;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    localparam int c_stall = 0, c_valid = 1, c_op1 = 2, c_op2 = 3,
                   c_dst = 4, c_regw = 5, c_memr = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            c_stall: obs = {31'd0, stall_id};
            c_valid: obs = {31'd0, ex_valid};
            c_op1:   obs = ex_op1;
            c_op2:   obs = ex_op2;
            c_dst:   obs = {27'd0, ex_dst};
            c_regw:  obs = {31'd0, ex_reg_write};
            default: obs = {31'd0, ex_mem_read};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.v = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs(e.sel), e.v);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_reg_write = 0; id_mem_read = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; rf_data1 = 0; rf_data2 = 0;
        mem_reg_write = 0; mem_dst = 0; mem_data = 0;
        wb_reg_write = 0; wb_dst = 0; wb_data = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_load(input logic [4:0] dst, input logic [4:0] rs);
        id_valid = 1; id_mem_read = 1; id_reg_write = 1;
        id_dst = dst; id_rs = rs; id_rt = 5'd2;
    endtask

    // Behavioural model of the EX slot for the randomized phase
    logic        m_valid, m_rw, m_mr;
    logic [4:0]  m_dst, m_rs, m_rt;
    logic [31:0] m_v1, m_v2;

    function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] v);
        if (s == 0)                          m_fwd = 0;
        else if (mem_reg_write && mem_dst == s) m_fwd = mem_data;
        else if (wb_reg_write && wb_dst == s)   m_fwd = wb_data;
        else                                 m_fwd = v;
    endfunction

    function automatic logic [31:0] m_byp(input logic [4:0] s, input logic [31:0] v);
        m_byp = (wb_reg_write && wb_dst == s && s != 0) ? wb_data : v;
    endfunction

    initial begin
        logic m_stall, m_issue;
        reset = 1;
        idle();
        #12 reset = 0;
        step();

        // Reset while a load-use stall is pending
        id_load(5'd8, 5'd1); rf_data1 = 32'h33;
        step();
        id_mem_read = 0; id_dst = 5'd9; id_rs = 5'd8;
        mem_reg_write = 1; mem_dst = 5'd1; mem_data = 32'h55;
        #1 push("rst_pre_stall", c_stall, 1); drain();
        #1 reset = 1;
        #1;
        push("rst_stall", c_stall, 0); push("rst_valid", c_valid, 0);
        push("rst_op1", c_op1, 0);     push("rst_op2", c_op2, 0);
        push("rst_dst", c_dst, 0);     push("rst_memr", c_memr, 0);
        push("rst_regw", c_regw, 0);
        drain();
        step();
        push("rst_hold_valid", c_valid, 0); push("rst_hold_op1", c_op1, 0);
        drain();
        idle();
        #2 reset = 0;
        step();

        // Same-cycle WB bypass at ID
        id_valid = 1; id_rs = 5'd5; id_dst = 5'd6; id_reg_write = 1; rf_data1 = 32'h11;
        wb_reg_write = 1; wb_dst = 5'd5; wb_data = 32'h22;
        step();
        idle();
        #1;
        push("byp_valid", c_valid, 1); push("byp_op1", c_op1, 32'h22);
        push("byp_dst", c_dst, 6);     push("byp_regw", c_regw, 1);
        push("byp_op2_r0", c_op2, 0);
        drain();

        // ALU result forwarded from MEM, no stall
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_dst = 5'd3; id_reg_write = 1;
        rf_data1 = 32'h10; rf_data2 = 32'h20;
        step();
        id_rs = 5'd4; id_rt = 5'd3; id_dst = 5'd7; rf_data1 = 32'h44; rf_data2 = 32'hDEAD;
        #1;
        push("alu_op1", c_op1, 32'h10); push("alu_op2", c_op2, 32'h20);
        push("alu_nostall", c_stall, 0);
        drain();
        step();
        idle();
        mem_reg_write = 1; mem_dst = 5'd3; mem_data = 32'h1234;
        #1;
        push("memfwd_op2", c_op2, 32'h1234); push("memfwd_op1", c_op1, 32'h44);
        push("memfwd_valid", c_valid, 1);
        drain();
        idle();

        // Load-use: one stall, one bubble, then WB forwarding
        id_load(5'd8, 5'd1);
        step();
        id_mem_read = 0; id_rs = 5'd8; id_rt = 5'd2; id_dst = 5'd9;
        rf_data1 = 0; rf_data2 = 32'h77;
        #1 push("lu_stall", c_stall, 1); push("lu_memr", c_memr, 1); drain();
        step();
        push("lu_bub_stall", c_stall, 0); push("lu_bub_valid", c_valid, 0);
        push("lu_bub_regw", c_regw, 0);   push("lu_bub_memr", c_memr, 0);
        drain();
        step();
        id_valid = 0;
        wb_reg_write = 1; wb_dst = 5'd8; wb_data = 32'hBEEF;
        #1;
        push("lu_valid", c_valid, 1);  push("lu_op1", c_op1, 32'hBEEF);
        push("lu_op2", c_op2, 32'h77); push("lu_dst", c_dst, 9);
        drain();
        idle();

        // MEM beats WB; r0 never forwards
        id_valid = 1; id_rs = 5'd9; id_dst = 5'd10; id_reg_write = 1; rf_data1 = 32'h5;
        step();
        idle();
        mem_reg_write = 1; mem_dst = 5'd9; mem_data = 32'hA;
        wb_reg_write = 1;  wb_dst = 5'd9;  wb_data = 32'hB;
        #1 push("prio_mem", c_op1, 32'hA); drain();
        mem_reg_write = 0;
        #1 push("prio_wb", c_op1, 32'hB); drain();
        wb_reg_write = 0;
        #1 push("prio_reg", c_op1, 32'h5); drain();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0; rf_data1 = 32'h99; rf_data2 = 32'h98;
        step();
        idle();
        mem_reg_write = 1; mem_dst = 5'd0; mem_data = 32'hFFFF;
        wb_reg_write = 1;  wb_dst = 5'd0;  wb_data = 32'h1;
        #1 push("r0_op1", c_op1, 0); push("r0_op2", c_op2, 0); drain();
        idle();

        // Flush overrides a load-use stall
        id_load(5'd8, 5'd1);
        step();
        id_mem_read = 0; id_rs = 5'd8; id_dst = 5'd9; flush = 1;
        #1 push("fl_stall", c_stall, 0); drain();
        step();
        flush = 0; id_valid = 0;
        #1;
        push("fl_valid", c_valid, 0); push("fl_regw", c_regw, 0);
        push("fl_memr", c_memr, 0);
        drain();
        idle();

        // Randomized phase against the model
        #1 reset = 1;
        #2 reset = 0;
        m_valid = 0; m_rw = 0; m_mr = 0; m_dst = 0; m_rs = 0; m_rt = 0; m_v1 = 0; m_v2 = 0;
        step();
        for (int i = 0; i < 300; i++) begin
            id_valid      = ($urandom_range(3) != 0);
            id_rs         = 5'($urandom_range(3));
            id_rt         = 5'($urandom_range(3));
            id_dst        = 5'($urandom_range(3));
            id_reg_write  = 1'($urandom_range(1));
            id_mem_read   = ($urandom_range(2) == 0);
            rf_data1      = $urandom;
            rf_data2      = $urandom;
            mem_reg_write = 1'($urandom_range(1));
            mem_dst       = 5'($urandom_range(3));
            mem_data      = $urandom;
            wb_reg_write  = 1'($urandom_range(1));
            wb_dst        = 5'($urandom_range(3));
            wb_data       = $urandom;
            flush         = ($urandom_range(7) == 0);
            #1;
            m_stall = id_valid && m_valid && m_mr && (m_dst != 0)
                      && (m_dst == id_rs || m_dst == id_rt) && !flush;
            push("rnd_stall", c_stall, {31'd0, m_stall});
            push("rnd_valid", c_valid, {31'd0, m_valid});
            push("rnd_regw", c_regw, {31'd0, m_rw});
            push("rnd_memr", c_memr, {31'd0, m_mr});
            if (m_valid) begin
                push("rnd_op1", c_op1, m_fwd(m_rs, m_v1));
                push("rnd_op2", c_op2, m_fwd(m_rt, m_v2));
                push("rnd_dst", c_dst, {27'd0, m_dst});
            end
            drain();
            m_issue = id_valid && !flush && !m_stall;
            m_valid = m_issue;
            m_rw    = m_issue && id_reg_write;
            m_mr    = m_issue && id_mem_read;
            m_dst   = id_dst;
            m_rs    = id_rs;
            m_rt    = id_rt;
            m_v1    = m_byp(id_rs, rf_data1);
            m_v2    = m_byp(id_rt, rf_data2);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
